// File: rtl/imm_decode_if.sv
// Handshake bundle for the immediate-decode stage.
// The producer drives the input side and the consumer drives out_ready; the stage uses the slave view.
interface imm_decode_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic [XLEN-1:0]  out_target;
    logic             out_unsup;
    logic [CNT_W-1:0] unsup_count;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_imm, out_fmt, out_target, out_unsup, unsup_count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_imm, out_fmt, out_target, out_unsup, unsup_count
    );
endinterface

// File: rtl/imm_decode_stage.sv
// Pipelined RISC-V immediate decoder with PC-relative target and a 2-entry skid buffer.
// Register M drives the outputs, S absorbs one extra entry while M is stalled.
module imm_decode_stage #(
    parameter int XLEN      = 32,
    parameter bit ENABLE_UJ = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    imm_decode_if.slave bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_UNSUP = 3'd7;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] target;
        logic            unsup;
    } entry_t;

    // Widen a 32-bit value to XLEN by replicating bit 31.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [31:0]      instr_s;
    logic [6:0]       opcode_s;
    logic [2:0]       funct3_s;
    logic [31:0]      shamt_s;
    logic [31:0]      imm32_s;
    logic [2:0]       fmt_s;
    logic             unsup_s;
    logic             pc_rel_s;
    entry_t           dec_s;
    logic             accept_s;
    logic             retire_s;

    entry_t           m_q, m_d, s_q, s_d;
    logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign instr_s  = bus.in_instr;
    assign opcode_s = instr_s[6:0];
    assign funct3_s = instr_s[14:12];
    // funct7 bits are excluded; RV64 uses a 6-bit shamt, RV32 a 5-bit one.
    assign shamt_s  = (XLEN == 64) ? {26'd0, instr_s[25:20]} : {27'd0, instr_s[24:20]};

    // Opcode decode into a 32-bit immediate that is already sign-correct at bit 31
    // (shamt has bit 31 clear, so widening it with sext32 zero-extends it).
    always_comb begin
        imm32_s  = 32'd0;
        fmt_s    = FMT_UNSUP;
        unsup_s  = 1'b1;
        pc_rel_s = 1'b0;
        case (opcode_s)
            OP_R: begin
                fmt_s   = FMT_R;
                unsup_s = 1'b0;
            end
            OP_LOAD, OP_JALR: begin
                imm32_s = {{20{instr_s[31]}}, instr_s[31:20]};
                fmt_s   = FMT_I;
                unsup_s = 1'b0;
            end
            OP_IMM: begin
                fmt_s   = FMT_I;
                unsup_s = 1'b0;
                if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                    imm32_s = shamt_s;
                end else begin
                    imm32_s = {{20{instr_s[31]}}, instr_s[31:20]};
                end
            end
            OP_STORE: begin
                imm32_s = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
                fmt_s   = FMT_S;
                unsup_s = 1'b0;
            end
            OP_BRANCH: begin
                imm32_s  = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
                fmt_s    = FMT_B;
                unsup_s  = 1'b0;
                pc_rel_s = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                if (ENABLE_UJ) begin
                    imm32_s  = {instr_s[31:12], 12'd0};
                    fmt_s    = FMT_U;
                    unsup_s  = 1'b0;
                    pc_rel_s = (opcode_s == OP_AUIPC);
                end else begin
                    imm32_s  = 32'd0;
                    fmt_s    = FMT_UNSUP;
                    unsup_s  = 1'b1;
                    pc_rel_s = 1'b0;
                end
            end
            OP_JAL: begin
                if (ENABLE_UJ) begin
                    imm32_s  = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
                    fmt_s    = FMT_J;
                    unsup_s  = 1'b0;
                    pc_rel_s = 1'b1;
                end else begin
                    imm32_s  = 32'd0;
                    fmt_s    = FMT_UNSUP;
                    unsup_s  = 1'b1;
                    pc_rel_s = 1'b0;
                end
            end
            default: begin
                imm32_s  = 32'd0;
                fmt_s    = FMT_UNSUP;
                unsup_s  = 1'b1;
                pc_rel_s = 1'b0;
            end
        endcase
    end

    // Assemble the decoded entry; target addition wraps modulo 2^XLEN.
    always_comb begin
        dec_s.instr = instr_s;
        dec_s.imm   = sext32(imm32_s);
        dec_s.fmt   = fmt_s;
        dec_s.unsup = unsup_s;
        if (pc_rel_s) begin
            dec_s.target = bus.in_pc + dec_s.imm;
        end else begin
            dec_s.target = bus.in_pc + XLEN'(3'd4);
        end
    end

    assign bus.in_ready = !s_valid_q && !rst;
    assign accept_s     = bus.in_valid && bus.in_ready;
    assign retire_s     = m_valid_q && bus.out_ready;

    // Skid-buffer steering and saturating unsupported-instruction counter.
    always_comb begin
        m_d       = m_q;
        m_valid_d = m_valid_q;
        s_d       = s_q;
        s_valid_d = s_valid_q;
        if (retire_s) begin
            if (s_valid_q) begin
                m_d       = s_q;
                s_valid_d = 1'b0;
            end else if (accept_s) begin
                m_d = dec_s;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept_s) begin
            if (m_valid_q) begin
                s_d       = dec_s;
                s_valid_d = 1'b1;
            end else begin
                m_d       = dec_s;
                m_valid_d = 1'b1;
            end
        end else begin
            m_valid_d = m_valid_q;
        end
        if (accept_s && dec_s.unsup && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stage registers with synchronous reset discarding all buffered entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.out_valid   = m_valid_q;
    assign bus.out_instr   = m_q.instr;
    assign bus.out_imm     = m_q.imm;
    assign bus.out_fmt     = m_q.fmt;
    assign bus.out_target  = m_q.target;
    assign bus.out_unsup   = m_q.unsup;
    assign bus.unsup_count = cnt_q;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench: three stage instances (RV32 full, RV64 with 2-bit counter, RV32 without U/J).
module tb_imm_decode_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    imm_decode_if #(.XLEN(32), .CNT_W(16)) if_a ();
    imm_decode_if #(.XLEN(64), .CNT_W(2))  if_b ();
    imm_decode_if #(.XLEN(32), .CNT_W(16)) if_c ();

    imm_decode_stage #(.XLEN(32), .ENABLE_UJ(1'b1), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    imm_decode_stage #(.XLEN(64), .ENABLE_UJ(1'b1), .CNT_W(2))  u_b (.clk(clk), .rst(rst), .bus(if_b));
    imm_decode_stage #(.XLEN(32), .ENABLE_UJ(1'b0), .CNT_W(16)) u_c (.clk(clk), .rst(rst), .bus(if_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic exp_out(input string tag, input logic v, input logic [63:0] imm, input logic [2:0] fmt,
                           input logic [63:0] tgt, input logic un, input logic [31:0] ins,
                           input logic [63:0] e_imm, input logic [2:0] e_fmt, input logic [63:0] e_tgt,
                           input logic e_un, input logic [31:0] e_ins);
        chk({tag, ".valid"},  64'(v),   64'd1);
        chk({tag, ".imm"},    imm,      e_imm);
        chk({tag, ".fmt"},    64'(fmt), 64'(e_fmt));
        chk({tag, ".target"}, tgt,      e_tgt);
        chk({tag, ".unsup"},  64'(un),  64'(e_un));
        chk({tag, ".instr"},  64'(ins), 64'(e_ins));
    endtask

    task automatic exp_a(input string tag, input logic [31:0] ins, input logic [31:0] imm,
                         input logic [2:0] fmt, input logic [31:0] tgt, input logic un);
        exp_out(tag, if_a.out_valid, 64'(if_a.out_imm), if_a.out_fmt, 64'(if_a.out_target),
                if_a.out_unsup, if_a.out_instr, 64'(imm), fmt, 64'(tgt), un, ins);
    endtask

    task automatic exp_b(input string tag, input logic [31:0] ins, input logic [63:0] imm,
                         input logic [2:0] fmt, input logic [63:0] tgt, input logic un);
        exp_out(tag, if_b.out_valid, if_b.out_imm, if_b.out_fmt, if_b.out_target,
                if_b.out_unsup, if_b.out_instr, imm, fmt, tgt, un, ins);
    endtask

    task automatic exp_c(input string tag, input logic [31:0] ins, input logic [31:0] imm,
                         input logic [2:0] fmt, input logic [31:0] tgt, input logic un);
        exp_out(tag, if_c.out_valid, 64'(if_c.out_imm), if_c.out_fmt, 64'(if_c.out_target),
                if_c.out_unsup, if_c.out_instr, 64'(imm), fmt, 64'(tgt), un, ins);
    endtask

    task automatic send_a(input logic [31:0] ins, input logic [31:0] pc);
        if_a.in_valid = 1'b1; if_a.in_instr = ins; if_a.in_pc = pc;
        step();
        if_a.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] ins, input logic [63:0] pc);
        if_b.in_valid = 1'b1; if_b.in_instr = ins; if_b.in_pc = pc;
        step();
        if_b.in_valid = 1'b0;
    endtask

    task automatic send_c(input logic [31:0] ins, input logic [31:0] pc);
        if_c.in_valid = 1'b1; if_c.in_instr = ins; if_c.in_pc = pc;
        step();
        if_c.in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_a.in_valid = 1'b0; if_a.in_instr = 32'd0; if_a.in_pc = 32'd0; if_a.out_ready = 1'b1;
        if_b.in_valid = 1'b0; if_b.in_instr = 32'd0; if_b.in_pc = 64'd0; if_b.out_ready = 1'b1;
        if_c.in_valid = 1'b0; if_c.in_instr = 32'd0; if_c.in_pc = 32'd0; if_c.out_ready = 1'b1;
        step();
        step();

        // Reset state
        chk("rst.valid",  64'(if_a.out_valid),   64'd0);
        chk("rst.imm",    64'(if_a.out_imm),     64'd0);
        chk("rst.target", 64'(if_a.out_target),  64'd0);
        chk("rst.fmt",    64'(if_a.out_fmt),     64'd0);
        chk("rst.instr",  64'(if_a.out_instr),   64'd0);
        chk("rst.unsup",  64'(if_a.out_unsup),   64'd0);
        chk("rst.count",  64'(if_a.unsup_count), 64'd0);
        chk("rst.ready",  64'(if_a.in_ready),    64'd0);
        chk("rst.b.imm",  if_b.out_imm,          64'd0);
        rst = 1'b0;
        #1;
        chk("rst.ready_after", 64'(if_a.in_ready), 64'd1);

        // RV32 decode of every format
        send_a(32'hFFC12083, 32'h0000_0100); exp_a("a.lw",      32'hFFC12083, 32'hFFFF_FFFC, 3'd1, 32'h0000_0104, 1'b0);
        send_a(32'hFE000CE3, 32'h0000_0200); exp_a("a.beq",     32'hFE000CE3, 32'hFFFF_FFF8, 3'd3, 32'h0000_01F8, 1'b0);
        send_a(32'hFE000CE3, 32'h0000_0000); exp_a("a.beqwrap", 32'hFE000CE3, 32'hFFFF_FFF8, 3'd3, 32'hFFFF_FFF8, 1'b0);
        send_a(32'hFE112E23, 32'h0000_0010); exp_a("a.sw",      32'hFE112E23, 32'hFFFF_FFFC, 3'd2, 32'h0000_0014, 1'b0);
        send_a(32'h002081B3, 32'h0000_0020); exp_a("a.add",     32'h002081B3, 32'h0000_0000, 3'd0, 32'h0000_0024, 1'b0);
        send_a(32'h123452B7, 32'h0000_0030); exp_a("a.lui",     32'h123452B7, 32'h1234_5000, 3'd4, 32'h0000_0034, 1'b0);
        send_a(32'h00001117, 32'h0000_0100); exp_a("a.auipc",   32'h00001117, 32'h0000_1000, 3'd4, 32'h0000_1100, 1'b0);
        send_a(32'hFFDFF06F, 32'h0000_0500); exp_a("a.jal",     32'hFFDFF06F, 32'hFFFF_FFFC, 3'd5, 32'h0000_04FC, 1'b0);
        send_a(32'h4030D093, 32'h0000_0040); exp_a("a.srai",    32'h4030D093, 32'h0000_0003, 3'd1, 32'h0000_0044, 1'b0);
        send_a(32'h4230D093, 32'h0000_0040); exp_a("a.srai5b",  32'h4230D093, 32'h0000_0003, 3'd1, 32'h0000_0044, 1'b0);
        send_a(32'h0000000B, 32'h0000_0050); exp_a("a.unsup",   32'h0000000B, 32'h0000_0000, 3'd7, 32'h0000_0054, 1'b1);
        chk("a.count1", 64'(if_a.unsup_count), 64'd1);
        step();
        chk("a.drain", 64'(if_a.out_valid), 64'd0);

        // RV64 decode
        send_b(32'h800002B7, 64'h0000_1000); exp_b("b.lui", 32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 64'h0000_1004, 1'b0);
        send_b(32'h4230D093, 64'h0000_1000); exp_b("b.srai", 32'h4230D093, 64'h0000_0000_0000_0023, 3'd1, 64'h0000_1004, 1'b0);
        send_b(32'hFE000CE3, 64'h0000_0000); exp_b("b.beqwrap", 32'hFE000CE3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);

        // Saturating 2-bit counter
        send_b(32'h0000000B, 64'h0); chk("b.cnt1", 64'(if_b.unsup_count), 64'd1);
        send_b(32'h0000000B, 64'h0); chk("b.cnt2", 64'(if_b.unsup_count), 64'd2);
        send_b(32'h0000000B, 64'h0); chk("b.cnt3", 64'(if_b.unsup_count), 64'd3);
        send_b(32'h0000000B, 64'h0); chk("b.cnt4", 64'(if_b.unsup_count), 64'd3);
        send_b(32'h0000000B, 64'h0); chk("b.cnt5", 64'(if_b.unsup_count), 64'd3);

        // U/J disabled
        send_c(32'h0000006F, 32'h0000_0040); exp_c("c.jal",   32'h0000006F, 32'h0, 3'd7, 32'h0000_0044, 1'b1);
        send_c(32'h00001117, 32'h0000_0040); exp_c("c.auipc", 32'h00001117, 32'h0, 3'd7, 32'h0000_0044, 1'b1);
        send_c(32'h123452B7, 32'h0000_0040); exp_c("c.lui",   32'h123452B7, 32'h0, 3'd7, 32'h0000_0044, 1'b1);
        send_c(32'hFFC12083, 32'h0000_0100); exp_c("c.lw",    32'hFFC12083, 32'hFFFF_FFFC, 3'd1, 32'h0000_0104, 1'b0);
        chk("c.count", 64'(if_c.unsup_count), 64'd3);

        // Backpressure: out_ready low for three edges while streaming four instructions
        if_a.out_ready = 1'b0;
        if_a.in_valid = 1'b1; if_a.in_instr = 32'hFFC12083; if_a.in_pc = 32'h100;
        #1; chk("bp.ready0", 64'(if_a.in_ready), 64'd1);
        step();
        exp_a("bp.m1", 32'hFFC12083, 32'hFFFF_FFFC, 3'd1, 32'h104, 1'b0);
        if_a.in_instr = 32'hFE000CE3; if_a.in_pc = 32'h200;
        #1; chk("bp.ready1", 64'(if_a.in_ready), 64'd1);
        step();
        chk("bp.ready2", 64'(if_a.in_ready), 64'd0);
        exp_a("bp.hold1", 32'hFFC12083, 32'hFFFF_FFFC, 3'd1, 32'h104, 1'b0);
        if_a.in_instr = 32'h123452B7; if_a.in_pc = 32'h300;
        step();
        chk("bp.ready3", 64'(if_a.in_ready), 64'd0);
        exp_a("bp.hold2", 32'hFFC12083, 32'hFFFF_FFFC, 3'd1, 32'h104, 1'b0);
        if_a.out_ready = 1'b1;
        step();
        exp_a("bp.r2", 32'hFE000CE3, 32'hFFFF_FFF8, 3'd3, 32'h1F8, 1'b0);
        chk("bp.ready4", 64'(if_a.in_ready), 64'd1);
        step();
        exp_a("bp.r3", 32'h123452B7, 32'h1234_5000, 3'd4, 32'h304, 1'b0);
        if_a.in_instr = 32'h4030D093; if_a.in_pc = 32'h400;
        step();
        exp_a("bp.r4", 32'h4030D093, 32'h0000_0003, 3'd1, 32'h404, 1'b0);
        if_a.in_valid = 1'b0;
        step();
        chk("bp.empty", 64'(if_a.out_valid), 64'd0);

        // Reset mid-stream with both buffer entries full
        if_b.out_ready = 1'b0;
        send_b(32'h0000000B, 64'h0);
        send_b(32'h0000000B, 64'h0);
        chk("mr.full", 64'(if_b.in_ready), 64'd0);
        rst = 1'b1;
        if_b.in_valid = 1'b1; if_b.in_instr = 32'h0000000B;
        step();
        chk("mr.valid", 64'(if_b.out_valid),   64'd0);
        chk("mr.count", 64'(if_b.unsup_count), 64'd0);
        chk("mr.ready", 64'(if_b.in_ready),    64'd0);
        rst = 1'b0;
        if_b.in_valid = 1'b0; if_b.out_ready = 1'b1;
        #1; chk("mr.ready_after", 64'(if_b.in_ready), 64'd1);
        step();
        chk("mr.nostale1", 64'(if_b.out_valid), 64'd0);
        step();
        chk("mr.nostale2", 64'(if_b.out_valid), 64'd0);
        send_b(32'hFFC12083, 64'h10); exp_b("mr.lw", 32'hFFC12083, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 64'h14, 1'b0);
        chk("mr.count0", 64'(if_b.unsup_count), 64'd0);
        send_b(32'h0000000B, 64'h0);
        chk("mr.count1", 64'(if_b.unsup_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
